// File: rtl/serial_addsub4.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub4
// Description : Bit-serial adder/subtractor that processes one bit per cycle,
//               LSB first, and reports the result with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic w_bit;
    logic w_ax;
    logic w_cout;

    // Inverting the a bit turns the carry majority into the borrow equation.
    assign w_bit  = r_a[0] ^ r_b[0] ^ r_c;
    assign w_ax   = r_a[0] ^ r_sub;
    assign w_cout = (w_ax & r_b[0]) | (w_ax & r_c) | (r_b[0] & r_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            s       <= '0;
            co      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= ci;
                        r_sub   <= sub;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_shift;
                    end
                end
                c_shift: begin
                    // r_a doubles as the result shift register.
                    r_a   <= {w_bit, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_c   <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        s       <= {w_bit, r_a[WIDTH-1:1]};
                        co      <= w_cout;
                        done    <= 1'b1;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
